// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: OAM DMA sequencer and CPU/DMA main-bus arbiter (optional FF46 readback: OAM_DMA_READBACK_EN)
module oam_dma_arbiter #(
  parameter int XFER_LEN    = 160,
  parameter int START_DELAY = 1
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        MCYC,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DO,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  output logic [7:0]  CPU_DI,
  output logic [15:0] BUS_A,
  output logic        BUS_RD,
  output logic        BUS_WR,
  output logic [7:0]  BUS_DO,
  input  logic [7:0]  BUS_DI,
  output logic [7:0]  OAM_A,
  output logic [7:0]  OAM_D,
  output logic        OAM_WE,
  output logic [7:0]  REG_DO,
  output logic        REG_OE,
  output logic        DMA_BUSY
);
  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
  localparam logic [7:0] DLY  = 8'(START_DELAY);
  typedef enum logic [1:0] {IDLE, START, XFER} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_src, r_idx, r_cnt, r_oam_a, r_oam_d;
  logic       r_oam_we;
  logic       w_trig, w_main, w_step;
  logic [7:0] w_page;
  assign w_trig   = MCYC & CPU_WR & (CPU_A == 16'hFF46);
  assign w_main   = CPU_A[15:8] != 8'hFF;
  assign w_step   = MCYC & (r_state == XFER);
  assign w_page   = r_src < 8'hE0 ? r_src : r_src - 8'h20;
  assign DMA_BUSY = r_state != IDLE;
  assign OAM_A    = r_oam_a;
  assign OAM_D    = r_oam_d;
  assign OAM_WE   = r_oam_we;
  assign REG_OE   = CPU_RD & (CPU_A == 16'hFF46);
`ifdef OAM_DMA_READBACK_EN
  assign REG_DO   = r_src;
`else
  assign REG_DO   = 8'hFF;
`endif
  // state register
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) r_state <= IDLE;
    else r_state <= w_next;
  // next state: a trigger always wins, even over the final byte
  always_comb begin
    w_next = r_state;
    if (w_trig) w_next = START_DELAY == 0 ? XFER : START;
    else if (MCYC && r_state == START && r_cnt == 8'd1) w_next = XFER;
    else if (w_step && r_idx == LAST) w_next = IDLE;
  end
  // datapath: source page, index, delay counter and the OAM write port
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      r_src    <= 8'h00;
      r_idx    <= 8'h00;
      r_cnt    <= 8'h00;
      r_oam_a  <= 8'h00;
      r_oam_d  <= 8'h00;
      r_oam_we <= 1'b0;
    end else begin
      r_oam_we <= w_step;
      if (w_step) begin
        r_oam_a <= r_idx;
        r_oam_d <= BUS_DI;
      end
      if (w_trig) begin
        r_src <= CPU_DO;
        r_cnt <= DLY;
        r_idx <= 8'h00;
      end else begin
        if (MCYC && r_state == START) r_cnt <= r_cnt - 8'd1;
        if (w_step) r_idx <= r_idx == LAST ? 8'h00 : r_idx + 8'd1;
      end
    end
  // outputs: DMA drives the bus in XFER; CPU main-bus traffic is blocked while busy
  always_comb begin
    BUS_A  = r_state == XFER ? {w_page, r_idx} : CPU_A;
    BUS_RD = (r_state == XFER) | (!DMA_BUSY & CPU_RD & w_main);
    BUS_WR = !DMA_BUSY & CPU_WR & w_main;
    BUS_DO = CPU_DO;
    CPU_DI = DMA_BUSY && w_main ? 8'hFF : BUS_DI;
  end
endmodule
